// File: rtl/data_path_sink.sv
// Receiving end of the 4-bit data-path bus: selects a source, captures the settled
// value and loads or accumulates it into one of four registers (r3 feeds back to the mux).
module data_path_sink (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [1:0] src,
    input  logic [1:0] dst,
    input  logic [3:0] data_path,
    output logic [1:0] select,
    output logic       busy,
    output logic       done,
    output logic       carry,
    output logic [3:0] r0,
    output logic [3:0] r1,
    output logic [3:0] r2,
    output logic [3:0] r3
);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StCapture,
        StWrite
    } state_e;

    state_e     state_q, state_d;
    logic       op_q;
    logic [1:0] src_q;
    logic [1:0] dst_q;
    logic [3:0] hold_q;
    logic [3:0] regs_q [0:3];
    logic       carry_q;
    logic       done_q;
    logic [4:0] sum;

    always_comb begin
        state_d = state_q;
        sum     = {1'b0, regs_q[dst_q]} + {1'b0, hold_q};
        case (state_q)
            StIdle:    if (start) state_d = StSelect;
            StSelect:  state_d = StCapture;
            StCapture: state_d = StWrite;
            StWrite:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            src_q   <= 2'b00;
            dst_q   <= 2'b00;
            hold_q  <= 4'h0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            // Fields are latched only on acceptance, so a start while busy cannot disturb them.
            if (state_q == StIdle && start) begin
                op_q  <= op;
                src_q <= src;
                dst_q <= dst;
            end
            if (state_q == StCapture) begin
                hold_q <= data_path;
            end
            if (state_q == StWrite) begin
                done_q <= 1'b1;
                if (op_q) begin
                    regs_q[dst_q] <= sum[3:0];
                    carry_q       <= sum[4];
                end else begin
                    regs_q[dst_q] <= hold_q;
                    carry_q       <= 1'b0;
                end
            end
        end
    end

    // Decoded from registered state only: no combinational path from start.
    assign busy   = (state_q != StIdle);
    assign select = busy ? src_q : 2'b00;
    assign done   = done_q;
    assign carry  = carry_q;
    assign r0     = regs_q[0];
    assign r1     = regs_q[1];
    assign r2     = regs_q[2];
    assign r3     = regs_q[3];

endmodule

// File: tb/tb_data_path_sink.sv
// Bench for data_path_sink: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_path_sink;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [1:0] src = 2'b00;
    logic [1:0] dst = 2'b00;
    logic [3:0] data_path;
    logic [1:0] select;
    logic       busy, done, carry;
    logic [3:0] r0, r1, r2, r3;
    logic [3:0] sw = 4'h0;
    logic [3:0] custom = 4'h0;

    int n_cmp = 0;
    int n_err = 0;

    data_path_sink dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src       (src),
        .dst       (dst),
        .data_path (data_path),
        .select    (select),
        .busy      (busy),
        .done      (done),
        .carry     (carry),
        .r0        (r0),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] mux(input logic [1:0] s, input logic [3:0] swv,
                                       input logic [3:0] r3v, input logic [3:0] cv);
        case (s)
            2'b00:   return 4'h0;
            2'b01:   return swv;
            2'b10:   return r3v;
            default: return cv;
        endcase
    endfunction

    // Multiplexer in front of the sink, closing the r3 feedback loop.
    always_comb data_path = mux(select, sw, r3, custom);

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation is in flight for three edges; the bus value
    // is taken on the second edge after acceptance and the result lands on the third.
    logic [3:0] m_r [0:3];
    logic       m_carry, m_done, m_valid = 1'b0;
    logic       m_inflight, m_op;
    logic [1:0] m_src, m_dst;
    logic [3:0] m_hold;
    int         cyc = 0;
    int         t0 = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
                m_carry    = 1'b0;
                m_done     = 1'b0;
                m_inflight = 1'b0;
                m_hold     = 4'h0;
                m_op       = 1'b0;
                m_src      = 2'b00;
                m_dst      = 2'b00;
                m_valid    = 1'b1;
            end else begin
                m_done = 1'b0;
                if (m_inflight) begin
                    if (cyc - t0 == 2) m_hold = mux(m_src, sw, m_r[3], custom);
                    if (cyc - t0 == 3) begin
                        if (m_op) begin
                            m_carry    = (int'(m_r[m_dst]) + int'(m_hold)) > 15;
                            m_r[m_dst] = 4'((int'(m_r[m_dst]) + int'(m_hold)) % 16);
                        end else begin
                            m_r[m_dst] = m_hold;
                            m_carry    = 1'b0;
                        end
                        m_done     = 1'b1;
                        m_inflight = 1'b0;
                    end
                end else if (start) begin
                    m_inflight = 1'b1;
                    t0         = cyc;
                    m_op       = op;
                    m_src      = src;
                    m_dst      = dst;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_select", 4'(select), m_inflight ? 4'(m_src) : 4'h0);
                chk("model_busy", 4'(busy), 4'(m_inflight));
                chk("model_done", 4'(done), 4'(m_done));
                chk("model_carry", 4'(carry), 4'(m_carry));
                chk("model_r0", r0, m_r[0]);
                chk("model_r1", r1, m_r[1]);
                chk("model_r2", r2, m_r[2]);
                chk("model_r3", r3, m_r[3]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Issue one operation from idle; returns 3 ns after the edge that writes the result.
    task automatic issue(input logic o, input logic [1:0] s, input logic [1:0] d);
        start = 1'b1;
        op    = o;
        src   = s;
        dst   = d;
        tick();
        start = 1'b0;
        chk("issue_select_1", 4'(select), 4'(s));
        chk("issue_busy_1", 4'(busy), 4'h1);
        tick();
        chk("issue_select_2", 4'(select), 4'(s));
        tick();
        chk("issue_select_3", 4'(select), 4'(s));
        chk("issue_done_early", 4'(done), 4'h0);
        tick();
        chk("issue_done", 4'(done), 4'h1);
        chk("issue_select_idle", 4'(select), 4'h0);
        chk("issue_busy_idle", 4'(busy), 4'h0);
    endtask

    initial begin
        int ndone;

        // Reset with start held high: nothing may be accepted.
        tick();
        rst   = 1'b1;
        start = 1'b1;
        src   = 2'b01;
        sw    = 4'h5;
        tick();
        chk("rst_done_a", 4'(done), 4'h0);
        tick();
        chk("rst_done_b", 4'(done), 4'h0);
        chk("rst_busy", 4'(busy), 4'h0);
        chk("rst_select", 4'(select), 4'h0);
        chk("rst_regs", r0 | r1 | r2 | r3, 4'h0);
        chk("rst_carry", 4'(carry), 4'h0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_done", 4'(done), 4'h0);

        // LOAD from switches.
        sw = 4'hA;
        issue(1'b0, 2'b01, 2'd2);
        chk("load_r2", r2, 4'hA);
        chk("load_carry", 4'(carry), 4'h0);
        chk("load_others", r0 | r1 | r3, 4'h0);
        tick();
        chk("load_done_once", 4'(done), 4'h0);

        // ADD with wrap, then LOAD clears carry.
        sw = 4'h9;
        issue(1'b0, 2'b01, 2'd1);
        tick();
        custom = 4'h8;
        issue(1'b1, 2'b11, 2'd1);
        chk("add_wrap_r1", r1, 4'h1);
        chk("add_wrap_carry", 4'(carry), 4'h1);
        tick();
        sw = 4'h3;
        issue(1'b0, 2'b01, 2'd0);
        chk("load3_r0", r0, 4'h3);
        chk("load3_carry", 4'(carry), 4'h0);
        tick();

        // r3 feedback: doubling.
        sw = 4'h5;
        issue(1'b0, 2'b01, 2'd3);
        tick();
        issue(1'b1, 2'b10, 2'd3);
        chk("fb_r3_a", r3, 4'hA);
        chk("fb_carry_a", 4'(carry), 4'h0);
        tick();
        issue(1'b1, 2'b10, 2'd3);
        chk("fb_r3_b", r3, 4'h4);
        chk("fb_carry_b", 4'(carry), 4'h1);
        tick();

        // start pulsed during CAPTURE with different fields is ignored.
        sw    = 4'h7;
        start = 1'b1;
        op    = 1'b0;
        src   = 2'b01;
        dst   = 2'd0;
        tick();
        start = 1'b0;
        tick();
        start  = 1'b1;
        op     = 1'b1;
        src    = 2'b11;
        dst    = 2'd2;
        custom = 4'h2;
        tick();
        start = 1'b0;
        chk("ign_select", 4'(select), 4'h1);
        tick();
        chk("ign_done", 4'(done), 4'h1);
        chk("ign_r0", r0, 4'h7);
        chk("ign_r2", r2, 4'hA);
        tick();
        chk("ign_not_queued", 4'(busy), 4'h0);

        // start held high continuously.
        start = 1'b1;
        op    = 1'b0;
        src   = 2'b01;
        dst   = 2'd1;
        sw    = 4'hC;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        chk("held_start_dones", 4'(ndone), 4'h3);
        for (int i = 0; i < 4; i++) tick();
        chk("held_r1", r1, 4'hC);

        // Reset during the WRITE cycle of a LOAD of F into r0 aborts it.
        sw    = 4'hF;
        start = 1'b1;
        op    = 1'b0;
        src   = 2'b01;
        dst   = 2'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_r0", r0, 4'h0);
        chk("abort_done", 4'(done), 4'h0);
        chk("abort_busy", 4'(busy), 4'h0);
        tick();
        chk("abort_done_after", 4'(done), 4'h0);
        chk("abort_r0_after", r0, 4'h0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 1) == 1);
            op     = 1'($urandom_range(0, 1));
            src    = 2'($urandom_range(0, 3));
            dst    = 2'($urandom_range(0, 3));
            sw     = 4'($urandom_range(0, 15));
            custom = 4'($urandom_range(0, 15));
            rst    = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
